icache: RTL and testbench
=========================

# icache

Direct-mapped, word-granular instruction cache that sits directly upstream of the instruction-fetch stage. It answers the fetch stage's lookup combinationally from a registered address and accepts a one-word fill after every miss the fetch stage completes over the byte-wide memory bus. It also supports a multi-cycle invalidate sweep for fence.i and keeps 32-bit hit and miss counters for performance bring-up.

## Interface
- INDEX_BITS, 7, log2 of line count; one 32-bit instruction per line; 128 lines = 512 B
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- raddr_i  in  32  lookup address from fetch; bits [1:0] ignored
- lookup_i  in  1  one-cycle strobe marking a new lookup, used for statistics only
- hit_o  out  1  raddr_i present and valid, combinational
- inst_o  out  32  cached instruction on hit, 0 on miss, combinational
- we_i  in  1  fill enable
- waddr_i  in  32  fill address; bits [1:0] ignored
- winst_i  in  32  fill instruction
- flush_i  in  1  start invalidate sweep, level-sampled
- busy_o  out  1  sweep in progress, registered
- hit_cnt_o  out  32  saturating count of strobed hits
- miss_cnt_o  out  32  saturating count of strobed misses

## Operation
- Address split: index = addr[INDEX_BITS+1:2]; tag = addr[31:INDEX_BITS+2], which is 23 bits at the default.
- Storage per line: valid bit in flops, tag, data. Tag and data are read asynchronously.
- Lookup: hit_o = valid[idx] & (tag[idx] == raddr tag) & (state == IDLE). inst_o = data[idx] when hit_o, else 32'h0.
- Fill, in IDLE with we_i high and flush_i low, at the clock edge:
  - valid[widx] <= 1
  - tag[widx] <= waddr tag
  - data[widx] <= winst_i
  - A fill overwrites any previous line at that index.
- States:
  - IDLE: flush_i high → FLUSH with sweep counter ptr <= 0.
  - FLUSH: each cycle valid[ptr] <= 0 and ptr <= ptr + 1. When ptr == 2^INDEX_BITS − 1, clear that line and return to IDLE.
- Behaviour in FLUSH:
  - we_i is ignored; the fill is dropped.
  - flush_i is ignored.
  - hit_o is forced to 0.
- Statistics, on a cycle with lookup_i high:
  - hit_cnt_o increments if hit_o, otherwise miss_cnt_o increments.
  - Both counters saturate at 32'hFFFFFFFF and never wrap.
- Reset:
  - All valid bits clear in the same edge.
  - State = IDLE, ptr = 0, busy_o = 0, hit_cnt_o = 0, miss_cnt_o = 0.
  - hit_o = 0 and inst_o = 0 from the first cycle after reset.
  - Tag and data arrays are not reset.
  - Reset mid-sweep aborts the sweep; the cache is fully invalid anyway.

## Timing
- Lookup latency is 0 cycles. hit_o and inst_o settle in the same cycle raddr_i changes. Fetch registers raddr_i and samples hit_o one edge later.
- Fill becomes visible the cycle after the we_i edge.
- A same-cycle fill and lookup to the same index returns the old content; no bypass.
- Flush:
  - flush_i sampled high at edge N → busy_o high from N+1.
  - The sweep takes exactly 2^INDEX_BITS cycles (128 at default).
  - busy_o low on the cycle after the last line clears.
- Simultaneous flush_i and we_i in IDLE: flush wins and the fill is dropped.
- busy_o is registered and equals (state == FLUSH).
- Counters update at the edge ending the strobed cycle. Counter values reflect the hit_o value of that cycle.

## Test plan
- Reset then lookup: rst 1 cycle; raddr_i = 0x0000_1000 with lookup_i → hit_o 0, inst_o 0, miss_cnt_o = 1, hit_cnt_o = 0.
- Fill then hit:
  - Fill waddr_i = 0x0000_1004, winst_i = 0x0010_0093.
  - Next cycle raddr_i = 0x0000_1006 → hit_o 1, inst_o 0x0010_0093 (low bits ignored).
  - With lookup_i → hit_cnt_o increments.
- Conflict eviction:
  - Fill 0x0000_1004 = 0xAAAA_AAAA, then 0x0000_1204 = 0xBBBB_BBBB (same index 1, different tag).
  - Lookup 0x1004 → miss; lookup 0x1204 → hit with 0xBBBB_BBBB.
- Same-cycle fill and read:
  - Line at 0x1004 holds 0x1111_1111; raddr_i = 0x1004 while filling 0x1004 = 0x2222_2222.
  - That cycle inst_o = 0x1111_1111; next cycle 0x2222_2222.
- Flush sweep:
  - Fill indices 0, 64, 127; pulse flush_i with a simultaneous fill to 0x0000_0008.
  - busy_o high for exactly 128 cycles; hit_o 0 throughout.
  - Afterwards all four addresses miss, and the fill to 0x0000_0008 was dropped.
- Saturation and reset mid-sweep:
  - Force miss_cnt_o to 0xFFFF_FFFE via repeated strobes (or a bench backdoor); two more misses → stays 0xFFFF_FFFF.
  - Assert rst during sweep cycle 40 → busy_o 0 and counters 0 the next cycle.

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache in front of the
// fetch stage. Lookups are answered combinationally. Fills are written at the
// clock edge. A fence.i sweep clears the valid bits one line per cycle.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   raddr_i       lookup address (bits [1:0] ignored)
//   lookup_i      strobe marking a new lookup (statistics only)
//   hit_o         raddr_i present and valid (combinational, 0 while sweeping)
//   inst_o        cached word on hit, 0 otherwise (combinational)
//   we_i          fill enable
//   waddr_i       fill address (bits [1:0] ignored)
//   winst_i       fill instruction
//   flush_i       start invalidate sweep (level-sampled in IDLE)
//   busy_o        sweep in progress (registered)
//   hit_cnt_o     saturating count of strobed hits
//   miss_cnt_o    saturating count of strobed misses
module icache #(
  parameter int unsigned INDEX_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] raddr_i,
  input  logic        lookup_i,
  output logic        hit_o,
  output logic [31:0] inst_o,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] winst_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [INDEX_BITS-1:0]  ptr_q, ptr_d;
  logic [LINES-1:0]       valid_q;
  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [31:0]            data_mem [LINES];
  logic [31:0]            hit_cnt_q, miss_cnt_q;

  logic [INDEX_BITS-1:0]  ridx, widx;
  logic [TAG_W-1:0]       rtag, wtag;
  logic                   fill_en, clr_en;

  // Word offset bits carry no information for a word-granular cache.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr_i[1:0], waddr_i[1:0]};

  assign ridx = raddr_i[INDEX_BITS+1:2];
  assign rtag = raddr_i[31:INDEX_BITS+2];
  assign widx = waddr_i[INDEX_BITS+1:2];
  assign wtag = waddr_i[31:INDEX_BITS+2];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH;
          ptr_d   = '0;
        end
      end
      FLUSH: begin
        ptr_d = ptr_q + INDEX_BITS'(1);
        if (&ptr_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    hit_o   = 1'b0;
    inst_o  = 32'h0;
    fill_en = 1'b0;
    clr_en  = 1'b0;
    busy_o  = (state_q == FLUSH);
    case (state_q)
      IDLE: begin
        hit_o   = valid_q[ridx] && (tag_mem[ridx] == rtag);
        // A flush request in the same cycle takes priority over the fill.
        fill_en = we_i && !flush_i;
      end
      FLUSH: begin
        clr_en = 1'b1;
      end
      default: ;
    endcase
    if (hit_o) inst_o = data_mem[ridx];
  end

  // Valid bits live in flops so they can be cleared together on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (fill_en) valid_q[widx]  <= 1'b1;
      if (clr_en)  valid_q[ptr_q] <= 1'b0;
    end
  end

  // Tag and data arrays: written on fill, read asynchronously, never reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[widx]  <= wtag;
      data_mem[widx] <= winst_i;
    end
  end

  // Statistics counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else if (lookup_i) begin
      if (hit_o) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a table of lookup/fill vectors followed by
// hand-written flush, saturation and reset-mid-sweep sequences.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raddr_i;
  logic        lookup_i;
  logic        hit_o;
  logic [31:0] inst_o;
  logic        we_i;
  logic [31:0] waddr_i;
  logic [31:0] winst_i;
  logic        flush_i;
  logic        busy_o;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  icache dut (
    .clk        (clk),
    .rst        (rst),
    .raddr_i    (raddr_i),
    .lookup_i   (lookup_i),
    .hit_o      (hit_o),
    .inst_o     (inst_o),
    .we_i       (we_i),
    .waddr_i    (waddr_i),
    .winst_i    (winst_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] winst;
    logic [31:0] raddr;
    logic        lookup;
    logic        exp_hit;
    logic [31:0] exp_inst;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] hits;
    logic [31:0] misses;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] waddr, input logic [31:0] winst,
                     input logic [31:0] raddr, input logic lookup, input logic exp_hit,
                     input logic [31:0] exp_inst, input logic [31:0] exp_hits,
                     input logic [31:0] exp_misses);
    vec_t v;
    v.we = we; v.waddr = waddr; v.winst = winst; v.raddr = raddr; v.lookup = lookup;
    v.exp_hit = exp_hit; v.exp_inst = exp_inst;
    v.exp_hits = exp_hits; v.exp_misses = exp_misses;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    we_i = 1'b0; waddr_i = 32'h0; winst_i = 32'h0;
    lookup_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   n;
    logic seen_hit;
    logic [31:0] post_addr [4];

    rst = 1'b1;
    raddr_i = 32'h0000_1004;
    idle_inputs();

    //   we  waddr         winst         raddr         lk hit inst          hits misses
    add(0, 32'h0,        32'h0,        32'h0000_1000, 1, 0, 32'h0,        0, 1);
    add(1, 32'h0000_1004, 32'h0010_0093, 32'h0000_1000, 0, 0, 32'h0,      0, 1);
    add(0, 32'h0,        32'h0,        32'h0000_1006, 1, 1, 32'h0010_0093, 1, 1);
    add(1, 32'h0000_1004, 32'hAAAA_AAAA, 32'h0000_1006, 1, 1, 32'h0010_0093, 2, 1);
    add(1, 32'h0000_1204, 32'hBBBB_BBBB, 32'h0000_1004, 1, 1, 32'hAAAA_AAAA, 3, 1);
    add(0, 32'h0,        32'h0,        32'h0000_1004, 1, 0, 32'h0,        3, 2);
    add(0, 32'h0,        32'h0,        32'h0000_1204, 1, 1, 32'hBBBB_BBBB, 4, 2);
    add(1, 32'h0000_1004, 32'h1111_1111, 32'h0000_1204, 0, 1, 32'hBBBB_BBBB, 4, 2);
    add(1, 32'h0000_1004, 32'h2222_2222, 32'h0000_1004, 1, 1, 32'h1111_1111, 5, 2);
    add(0, 32'h0,        32'h0,        32'h0000_1004, 1, 1, 32'h2222_2222, 6, 2);
    add(0, 32'h0,        32'h0,        32'h0000_2004, 1, 0, 32'h0,        6, 3);
    add(1, 32'h0000_0000, 32'hCAFE_0000, 32'h0000_0000, 1, 0, 32'h0,      6, 4);
    add(1, 32'h0000_0100, 32'h0000_0064, 32'h0000_0000, 1, 1, 32'hCAFE_0000, 7, 4);
    add(1, 32'h0000_01FC, 32'h0000_007F, 32'h0000_0100, 0, 1, 32'h0000_0064, 7, 4);
    add(0, 32'h0,        32'h0,        32'h0000_01FD, 1, 1, 32'h0000_007F, 8, 4);
    add(0, 32'h0,        32'h0,        32'hFFFF_FFFC, 1, 0, 32'h0,        8, 5);

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset busy", {31'h0, busy_o}, 32'h0);
    check("reset hit", {31'h0, hit_o}, 32'h0);
    check("reset inst", inst_o, 32'h0);
    check("reset hit_cnt", hit_cnt_o, 32'h0);
    check("reset miss_cnt", miss_cnt_o, 32'h0);
    @(negedge clk);

    // Table-driven vectors; counter expectations go through the scoreboard.
    for (int i = 0; i < vecs.size(); i++) begin
      we_i = vecs[i].we; waddr_i = vecs[i].waddr; winst_i = vecs[i].winst;
      raddr_i = vecs[i].raddr; lookup_i = vecs[i].lookup;
      #1;
      check($sformatf("vec%0d hit", i), {31'h0, hit_o}, {31'h0, vecs[i].exp_hit});
      check($sformatf("vec%0d inst", i), inst_o, vecs[i].exp_inst);
      e.idx = i; e.hits = vecs[i].exp_hits; e.misses = vecs[i].exp_misses;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("vec%0d hit_cnt", e.idx), hit_cnt_o, e.hits);
      check($sformatf("vec%0d miss_cnt", e.idx), miss_cnt_o, e.misses);
      $display("[TB] vec %0d raddr=%h hit=%b inst=%h hits=%0d misses=%0d",
               i, vecs[i].raddr, hit_o, inst_o, hit_cnt_o, miss_cnt_o);
    end
    idle_inputs();

    // Flush sweep with a simultaneous fill that must be dropped.
    flush_i = 1'b1; we_i = 1'b1; waddr_i = 32'h0000_0008; winst_i = 32'hDEAD_BEEF;
    raddr_i = 32'h0000_0000;
    #1;
    check("pre-flush hit", {31'h0, hit_o}, 32'h1);
    @(negedge clk);
    idle_inputs();
    n = 0;
    seen_hit = 1'b0;
    while (busy_o && n < 300) begin
      if (hit_o) seen_hit = 1'b1;
      n++;
      @(negedge clk);
    end
    check("flush busy cycles", n, 128);
    check("flush hit during sweep", {31'h0, seen_hit}, 32'h0);
    $display("[TB] flush sweep busy for %0d cycles", n);

    post_addr[0] = 32'h0000_0000; post_addr[1] = 32'h0000_0100;
    post_addr[2] = 32'h0000_01FC; post_addr[3] = 32'h0000_0008;
    for (int i = 0; i < 4; i++) begin
      raddr_i = post_addr[i]; lookup_i = 1'b1;
      #1;
      check($sformatf("post-flush hit %h", post_addr[i]), {31'h0, hit_o}, 32'h0);
      check($sformatf("post-flush inst %h", post_addr[i]), inst_o, 32'h0);
      @(negedge clk);
      $display("[TB] post-flush lookup %h hit=%b", post_addr[i], hit_o);
    end
    lookup_i = 1'b0;
    check("post-flush miss_cnt", miss_cnt_o, 32'd9);
    check("post-flush hit_cnt", hit_cnt_o, 32'd8);

    // Saturation: preload the miss counter, then two more misses.
    force dut.miss_cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.miss_cnt_q;
    #1;
    check("sat preload", miss_cnt_o, 32'hFFFF_FFFE);
    raddr_i = 32'h0004_0000; lookup_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("sat miss %0d", i), miss_cnt_o, 32'hFFFF_FFFF);
      $display("[TB] saturation step %0d miss_cnt=%h", i, miss_cnt_o);
    end
    lookup_i = 1'b0;
    check("sat hit_cnt", hit_cnt_o, 32'd8);

    // Reset mid-sweep at sweep cycle 40.
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("sweep2 busy", {31'h0, busy_o}, 32'h1);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    raddr_i = 32'h0000_1204;
    #1;
    check("midreset busy", {31'h0, busy_o}, 32'h0);
    check("midreset hit_cnt", hit_cnt_o, 32'h0);
    check("midreset miss_cnt", miss_cnt_o, 32'h0);
    check("midreset hit", {31'h0, hit_o}, 32'h0);
    $display("[TB] reset mid-sweep busy=%b hits=%0d misses=%0d", busy_o, hit_cnt_o, miss_cnt_o);

    // Cache is usable again after the aborted sweep.
    we_i = 1'b1; waddr_i = 32'h0000_1204; winst_i = 32'h0000_0005;
    @(negedge clk);
    we_i = 1'b0;
    #1;
    check("refill hit", {31'h0, hit_o}, 32'h1);
    check("refill inst", inst_o, 32'h0000_0005);
    $display("[TB] refill after reset hit=%b inst=%h", hit_o, inst_o);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
